// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the run-length detection controller.
// Optional feature macro: SEQ_POLARITY_SEL_EN (see run_detect_ctrl).
package seq_ctrl_pkg;

  localparam int RUN_W_D = 4;
  localparam int CNT_W_D = 8;
  localparam int WIN_W_D = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] POL_ONES  = 2'b01;
  localparam logic [1:0] POL_ZEROS = 2'b10;
  localparam logic [1:0] POL_BOTH  = 2'b11;

  function automatic logic pol_ok(
    input logic [1:0] pol,
    input logic       b
  );
    return (pol == 2'b00) || (b ? pol[0] : pol[1]);
  endfunction

endpackage

// File: rtl/run_len_tracker.sv
// Tracks the current run of identical bits; hit/hit_val are
// combinational for the beat being presented on x/x_valid.
module run_len_tracker
  import seq_ctrl_pkg::*;
#(
  parameter int RUN_W = RUN_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clear,
  input  logic [RUN_W-1:0] n,
  input  logic [1:0]       pol,
  output logic             hit,
  output logic             hit_val
);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] cnt_nxt;
  logic             last_bit;

  always_comb begin
    cnt_nxt = RUN_W'(1);
    if (run_cnt != '0 && x == last_bit)
      cnt_nxt = (run_cnt >= n) ? n : run_cnt + RUN_W'(1);
  end

  assign hit     = x_valid && (cnt_nxt == n) && pol_ok(pol, x);
  assign hit_val = x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (clear) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (x_valid) begin
      run_cnt  <= cnt_nxt;
      last_bit <= x;
    end
  end

endmodule

// File: rtl/run_detect_ctrl.sv
// Session FSM, match/beat counters and sticky irq around run_len_tracker.
// Define SEQ_POLARITY_SEL_EN to add the cfg_pol run-polarity filter.
module run_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int RUN_W = RUN_W_D,
  parameter int CNT_W = CNT_W_D,
  parameter int WIN_W = WIN_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [RUN_W-1:0] cfg_run_len,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [WIN_W-1:0] cfg_window,
`ifdef SEQ_POLARITY_SEL_EN
  input  logic [1:0]       cfg_pol,
`endif
  input  logic             x_valid,
  input  logic             x,
  input  logic             irq_clr,
  output logic             busy,
  output logic             hit,
  output logic             hit_val,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout,
  output logic             irq
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ARM  = ARM;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [RUN_W-1:0] n_q;
  logic [RUN_W-1:0] n_eff;
  logic [CNT_W-1:0] thr_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] beat_q;
  logic [WIN_W-1:0] beat_nxt;
  logic [CNT_W-1:0] match_nxt;
  logic [1:0]       pol;
  logic             in_arm;
  logic             beat;
  logic             trk_hit;
  logic             trk_val;
  logic             thr_end;
  logic             win_end;
  logic             finish;

`ifdef SEQ_POLARITY_SEL_EN
  logic [1:0] pol_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pol_q <= POL_BOTH;
    else if (state == S_ARM)
      pol_q <= cfg_pol;
  end
  assign pol = pol_q;
`else
  assign pol = POL_BOTH;
`endif

  assign in_arm = (state == S_ARM);
  assign beat   = (state == S_RUN) && x_valid && !stop;
  assign busy   = in_arm || (state == S_RUN);
  assign done   = (state == S_DONE);

  // Run lengths below 2 would hit on every beat; clamp to 2.
  assign n_eff = (cfg_run_len < RUN_W'(2)) ? RUN_W'(2) : cfg_run_len;

  assign match_nxt = (trk_hit && match_cnt != '1)
                   ? match_cnt + CNT_W'(1) : match_cnt;
  assign beat_nxt  = (beat_q != '1) ? beat_q + WIN_W'(1) : beat_q;
  assign thr_end   = (thr_q != '0) && (match_nxt == thr_q);
  assign win_end   = (win_q != '0) && (beat_nxt == win_q);
  assign finish    = beat && (thr_end || win_end);

  run_len_tracker #(.RUN_W(RUN_W)) u_trk (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .x_valid (beat),
    .clear   (in_arm),
    .n       (n_q),
    .pol     (pol),
    .hit     (trk_hit),
    .hit_val (trk_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      n_q       <= RUN_W'(2);
      thr_q     <= '0;
      win_q     <= '0;
      beat_q    <= '0;
      match_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start && !stop) state <= S_ARM;
        S_ARM: begin
          state     <= stop ? S_IDLE : S_RUN;
          n_q       <= n_eff;
          thr_q     <= cfg_thresh;
          win_q     <= cfg_window;
          beat_q    <= '0;
          match_cnt <= '0;
          timeout   <= 1'b0;
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (beat) begin
            beat_q    <= beat_nxt;
            match_cnt <= match_nxt;
            if (finish) begin
              state   <= S_DONE;
              timeout <= !thr_end;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit     <= 1'b0;
      hit_val <= 1'b0;
      irq     <= 1'b0;
    end else begin
      hit <= beat && trk_hit;
      if (beat && trk_hit)
        hit_val <= trk_val;
      irq <= finish || (irq && !irq_clr);
    end
  end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Directed-vector bench for run_detect_ctrl.
// Build with SEQ_POLARITY_SEL_EN to exercise cfg_pol.
module tb_run_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  cfg_run_len;
  logic [7:0]  cfg_thresh;
  logic [15:0] cfg_window;
`ifdef SEQ_POLARITY_SEL_EN
  logic [1:0]  cfg_pol;
`endif
  logic        x_valid;
  logic        x;
  logic        irq_clr;
  logic        busy;
  logic        hit;
  logic        hit_val;
  logic [7:0]  match_cnt;
  logic        done;
  logic        timeout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_run_len (cfg_run_len),
    .cfg_thresh  (cfg_thresh),
    .cfg_window  (cfg_window),
`ifdef SEQ_POLARITY_SEL_EN
    .cfg_pol     (cfg_pol),
`endif
    .x_valid     (x_valid),
    .x           (x),
    .irq_clr     (irq_clr),
    .busy        (busy),
    .hit         (hit),
    .hit_val     (hit_val),
    .match_cnt   (match_cnt),
    .done        (done),
    .timeout     (timeout),
    .irq         (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open(input logic [3:0] n,
                      input logic [7:0] thr,
                      input logic [15:0] win);
    cfg_run_len = n;
    cfg_thresh  = thr;
    cfg_window  = win;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send(input logic b);
    x = b;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [6:0] v1  = 7'b1111000;
  logic [6:0] h1  = 7'b0011001;
  logic [4:0] v3  = 5'b10101;
  logic [5:0] v6  = 6'b000111;
  int         hits;
  int         exp_hits;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_run_len = 4'd3; cfg_thresh = '0; cfg_window = '0;
`ifdef SEQ_POLARITY_SEL_EN
    cfg_pol = 2'b11;
`endif
    x_valid = 1'b0; x = 1'b0; irq_clr = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cnt", match_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // stop beats start in the same cycle
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    chk("ss_busy", busy, 0);

    // 1: overlapping runs, no termination
    open(4'd3, 8'd0, 16'd0);
    chk("t1_busy0", busy, 1);
    for (int i = 0; i < 7; i++) begin
      send(v1[6-i]);
      chk($sformatf("t1_hit%0d", i), hit, h1[6-i]);
      if (h1[6-i])
        chk($sformatf("t1_val%0d", i), hit_val, v1[6-i]);
    end
    chk("t1_cnt", match_cnt, 3);
    chk("t1_busy", busy, 1);
    chk("t1_done", done, 0);
    halt();
    chk("t1_stop_busy", busy, 0);
    chk("t1_stop_irq", irq, 0);

    // 2: threshold, irq set beats clear
    open(4'd3, 8'd2, 16'd0);
    send(1'b0); send(1'b0); send(1'b0);
    chk("t2_hit3", hit, 1);
    irq_clr = 1'b1;
    send(1'b0);
    chk("t2_hit4", hit, 1);
    chk("t2_done", done, 1);
    chk("t2_cnt", match_cnt, 2);
    chk("t2_irq", irq, 1);
    chk("t2_to", timeout, 0);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_done_off", done, 0);
    chk("t2_irq_clr", irq, 0);
    irq_clr = 1'b0;

    // 3: window timeout
    open(4'd3, 8'd0, 16'd5);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t3_nodone", done, 0);
      send(v3[4-i]);
      hits += int'(hit);
    end
    chk("t3_hits", hits, 0);
    chk("t3_done", done, 1);
    chk("t3_to", timeout, 1);
    chk("t3_cnt", match_cnt, 0);
    tick();
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;

    // 4: threshold wins the tie with the window
    open(4'd3, 8'd1, 16'd3);
    chk("t4_to_arm", timeout, 0);
    send(1'b1); send(1'b1); send(1'b1);
    chk("t4_done", done, 1);
    chk("t4_to", timeout, 0);
    tick();
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;

    // 5: gaps neither break nor extend the run
    open(4'd3, 8'd0, 16'd0);
    send(1'b1); tick();
    send(1'b1);
    chk("t5_gap_hit2", hit, 0);
    tick(); tick();
    send(1'b1);
    chk("t5_gap_hit3", hit, 1);
    halt();
    open(4'd3, 8'd0, 16'd0);
    send(1'b1); send(1'b1);
    halt();
    chk("t5_stop_busy", busy, 0);
    chk("t5_stop_done", done, 0);
    chk("t5_stop_irq", irq, 0);

    // run length 1 is treated as 2
    open(4'd1, 8'd0, 16'd0);
    send(1'b1);
    chk("n1_hit1", hit, 0);
    send(1'b1);
    chk("n1_hit2", hit, 1);

    // async reset mid-run
    send(1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hit", hit, 0);
    chk("arst_cnt", match_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // 6: polarity filter
`ifdef SEQ_POLARITY_SEL_EN
    cfg_pol = 2'b01;
    exp_hits = 1;
`else
    exp_hits = 2;
`endif
    open(4'd3, 8'd0, 16'd0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      send(v6[5-i]);
      hits += int'(hit);
    end
    chk("t6_hits", hits, exp_hits);
    chk("t6_val", hit_val, 1);
    halt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
